// File: rtl/move_button_ctrl.sv
// Debounces four active-low direction buttons and turns each accepted press into one
// fixed-width active-low move pulse. Optional auto-repeat: define MOVE_AUTO_REPEAT_EN.
module move_button_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int PULSE_CYCLES    = 5,
   parameter int GAP_CYCLES      = 5,
   parameter int REPEAT_CYCLES   = 12500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_right_n,
   input  logic       btn_left_n,
   input  logic       btn_up_n,
   input  logic       btn_down_n,
   output logic       mov_right,
   output logic       mov_left,
   output logic       mov_up,
   output logic       mov_down,
   output logic [1:0] move_dir,
   output logic       busy
);

   localparam int DW    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int T_A   = (DEBOUNCE_CYCLES + 2 > PULSE_CYCLES) ? DEBOUNCE_CYCLES + 2 : PULSE_CYCLES;
   localparam int T_B   = (T_A > GAP_CYCLES) ? T_A : GAP_CYCLES;
   localparam int T_MAX = (T_B > REPEAT_CYCLES) ? T_B : REPEAT_CYCLES;
   localparam int TW    = $clog2(T_MAX + 1);

   localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DB_ONE      = DW'(1);
   localparam logic [TW-1:0] T_ONE       = TW'(1);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(DEBOUNCE_CYCLES + 2);
   localparam logic [TW-1:0] PULSE_LAST  = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_CYCLES - 1);
`ifdef MOVE_AUTO_REPEAT_EN
   localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      ST_SETTLE = 3'd0,
      ST_IDLE   = 3'd1,
      ST_PULSE  = 3'd2,
      ST_GAP    = 3'd3,
      ST_WAIT   = 3'd4
   } state_t;

   // Bit order everywhere: [0] right, [1] left, [2] up, [3] down (matches move_dir).
   logic [3:0]          btn_s;
   logic [3:0]          sync1_q;
   logic [3:0]          sync2_q;
   logic [3:0]          db_q;
   logic [3:0]          db_d;
   logic [3:0][DW-1:0]  db_cnt_q;
   logic [3:0][DW-1:0]  db_cnt_d;

   state_t              state_q;
   state_t              state_d;
   logic [TW-1:0]       tmr_q;
   logic [TW-1:0]       tmr_d;
   logic [1:0]          dir_q;
   logic [1:0]          dir_d;
   logic [3:0]          mov_q;
   logic [3:0]          mov_d;
   logic                busy_q;
   logic                busy_d;

   assign btn_s = {btn_down_n, btn_up_n, btn_left_n, btn_right_n};

   function automatic logic [1:0] prio_dir(input logic [3:0] lvl_n);
      logic [1:0] d;
      if (!lvl_n[0]) begin
         d = 2'd0;
      end else if (!lvl_n[1]) begin
         d = 2'd1;
      end else if (!lvl_n[2]) begin
         d = 2'd2;
      end else begin
         d = 2'd3;
      end
      return d;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q  <= 4'b1111;
         sync2_q  <= 4'b1111;
         db_q     <= 4'b1111;
         db_cnt_q <= '0;
      end else begin
         sync1_q  <= btn_s;
         sync2_q  <= sync1_q;
         db_q     <= db_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   // The level flips on the (DEBOUNCE_CYCLES+1)-th consecutive differing sample.
   always_comb begin
      db_d     = db_q;
      db_cnt_d = '0;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] == db_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_LAST) begin
            db_d[i]     = sync2_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_SETTLE;
         tmr_q   <= '0;
         dir_q   <= 2'd0;
         mov_q   <= 4'b1111;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         dir_q   <= dir_d;
         mov_q   <= mov_d;
         busy_q  <= busy_d;
      end
   end

   // SETTLE outlasts the debounce latency so a button held through reset lands in WAIT.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      dir_d   = dir_q;
      case (state_q)
         ST_SETTLE: begin
            if (tmr_q == SETTLE_LAST) begin
               state_d = ST_WAIT;
               tmr_d   = '0;
            end else begin
               tmr_d   = tmr_q + T_ONE;
            end
         end
         ST_IDLE: begin
            tmr_d = '0;
            if (db_q != 4'b1111) begin
               state_d = ST_PULSE;
               dir_d   = prio_dir(db_q);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PULSE: begin
            if (tmr_q == PULSE_LAST) begin
               state_d = ST_GAP;
               tmr_d   = '0;
            end else begin
               tmr_d   = tmr_q + T_ONE;
            end
         end
         ST_GAP: begin
            if (tmr_q == GAP_LAST) begin
               state_d = ST_WAIT;
               tmr_d   = '0;
            end else begin
               tmr_d   = tmr_q + T_ONE;
            end
         end
         ST_WAIT: begin
            tmr_d = '0;
            if (db_q == 4'b1111) begin
               state_d = ST_IDLE;
`ifdef MOVE_AUTO_REPEAT_EN
            end else if (db_q == ~(4'b0001 << dir_q)) begin
               if (tmr_q == REPEAT_LAST) begin
                  state_d = ST_PULSE;
               end else begin
                  state_d = ST_WAIT;
                  tmr_d   = tmr_q + T_ONE;
               end
`endif
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_SETTLE;
            tmr_d   = '0;
         end
      endcase
   end

   always_comb begin
      mov_d = 4'b1111;
      if (state_d == ST_PULSE) begin
         mov_d[dir_d] = 1'b0;
      end else begin
         mov_d = 4'b1111;
      end
      if (state_d == ST_IDLE) begin
         busy_d = 1'b0;
      end else begin
         busy_d = 1'b1;
      end
   end

   assign mov_right = mov_q[0];
   assign mov_left  = mov_q[1];
   assign mov_up    = mov_q[2];
   assign mov_down  = mov_q[3];
   assign move_dir  = dir_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_move_button_ctrl.sv
// Self-checking bench for move_button_ctrl: directed scenarios plus random button
// activity, compared every cycle against a time-stamp based behavioural model.
module tb_move_button_ctrl;
   localparam int D = 4;
   localparam int P = 5;
   localparam int G = 5;
   localparam int R = 20;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] raw   = 4'hF;
   logic       mov_right, mov_left, mov_up, mov_down, busy;
   logic [1:0] move_dir;

   int checks   = 0;
   int failures = 0;

   always #10 clk = ~clk;

   move_button_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .PULSE_CYCLES   (P),
      .GAP_CYCLES     (G),
      .REPEAT_CYCLES  (R)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_right_n(raw[0]),
      .btn_left_n (raw[1]),
      .btn_up_n   (raw[2]),
      .btn_down_n (raw[3]),
      .mov_right  (mov_right),
      .mov_left   (mov_left),
      .mov_up     (mov_up),
      .mov_down   (mov_down),
      .move_dir   (move_dir),
      .busy       (busy)
   );

   // Model: raw sample history, debounced levels derived from run lengths, and
   // the controller described by time stamps (pulse start, release-check start).
   logic [3:0] hist[$];
   int         n;
   logic [3:0] m_db;
   bit         m_armed;
   int         m_rel_from;
   int         m_pstart;
   logic [1:0] m_dir;

   int         falls[4];
   int         lows[4];
   int         last_fall[4];
   logic [3:0] prev_obs = 4'hF;

   function automatic logic [3:0] raw_at(input int k);
      if (k < 1 || k > hist.size()) return 4'hF;
      return hist[k-1];
   endfunction

   function automatic logic [1:0] first_pressed(input logic [3:0] v);
      for (int b = 0; b < 4; b++) begin
         if (!v[b]) return 2'(b);
      end
      return 2'd3;
   endfunction

   task automatic model_reset();
      hist.delete();
      n          = 0;
      m_db       = 4'hF;
      m_armed    = 1'b0;
      m_rel_from = D + 3;
      m_pstart   = -1;
      m_dir      = 2'd0;
   endtask

   task automatic model_edge(input logic [3:0] smp);
      logic [3:0] db_prev;
      logic [3:0] ref_v;
      logic [3:0] old_v;
      bit         stable;
      hist.push_back(smp);
      n++;
      db_prev = m_db;
      ref_v   = raw_at(n - 2);
      for (int b = 0; b < 4; b++) begin
         stable = 1'b1;
         for (int j = 0; j <= D; j++) begin
            old_v = raw_at(n - 2 - j);
            if (old_v[b] != ref_v[b]) stable = 1'b0;
         end
         if (stable && ref_v[b] != db_prev[b]) m_db[b] = ref_v[b];
      end
      if (m_armed) begin
         if (db_prev != 4'hF) begin
            m_armed    = 1'b0;
            m_pstart   = n;
            m_rel_from = n + P + G;
            m_dir      = first_pressed(db_prev);
         end
      end else if (n > m_rel_from && db_prev == 4'hF) begin
         m_armed = 1'b1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h edge=%0d", tag, obs, exp_v, n);
      end
   endtask

   task automatic clr_stats();
      for (int b = 0; b < 4; b++) begin
         falls[b]     = 0;
         lows[b]      = 0;
         last_fall[b] = -1;
      end
   endtask

   task automatic cycle();
      logic [3:0] obs;
      logic [3:0] expm;
      @(posedge clk);
      model_edge(raw);
      #5;
      obs  = {mov_down, mov_up, mov_left, mov_right};
      expm = (m_pstart > 0 && n >= m_pstart && n < m_pstart + P) ? ~(4'b0001 << m_dir) : 4'hF;
      check("mov", 32'(obs), 32'(expm));
      check("busy", 32'(busy), 32'(!m_armed));
      check("move_dir", 32'(move_dir), 32'(m_dir));
      for (int b = 0; b < 4; b++) begin
         if (!obs[b]) lows[b]++;
         if (!obs[b] && prev_obs[b]) begin
            falls[b]++;
            last_fall[b] = n;
         end
      end
      prev_obs = obs;
   endtask

   task automatic run(input int cnt, input logic [3:0] v);
      raw = v;
      repeat (cnt) cycle();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #1;
      check("rst_mov", 32'({mov_down, mov_up, mov_left, mov_right}), 32'hF);
      check("rst_busy", 32'(busy), 32'h1);
      check("rst_dir", 32'(move_dir), 32'h0);
      repeat (3) begin
         @(posedge clk);
         #5;
         check("rst_hold_mov", 32'({mov_down, mov_up, mov_left, mov_right}), 32'hF);
         check("rst_hold_busy", 32'(busy), 32'h1);
      end
      reset = 1'b0;
      model_reset();
      prev_obs = 4'hF;
   endtask

   initial begin
      int         press_edge;
      int         total;
      int         len;
      int         kind;
      bit         found;
      logic [3:0] v;

      clr_stats();
      model_reset();
      #3;
      apply_reset();

      // Single right press held 5 cycles: pulse 7 edges after first low sample.
      run(15, 4'hF);
      clr_stats();
      press_edge = n + 1;
      run(5, 4'hE);
      run(30, 4'hF);
      check("s1_latency", 32'(last_fall[0] - press_edge), 32'd7);
      check("s1_width", 32'(lows[0]), 32'd5);
      check("s1_count", 32'(falls[0]), 32'd1);
      check("s1_others", 32'(lows[1] + lows[2] + lows[3]), 32'd0);

      // Bounce on down, then a stable hold.
      clr_stats();
      repeat (5) begin
         run(2, 4'h7);
         run(2, 4'hF);
      end
      check("s2_bounce", 32'(falls[3]), 32'd0);
      run(15, 4'h7);
      run(25, 4'hF);
      check("s2_count", 32'(falls[3]), 32'd1);
      check("s2_width", 32'(lows[3]), 32'd5);
      check("s2_dir", 32'(move_dir), 32'd3);

      // Up and left together: left wins, up needs a fresh press after full release.
      clr_stats();
      run(20, 4'h9);
      check("s3_left", 32'(falls[1]), 32'd1);
      check("s3_no_up", 32'(falls[2]), 32'd0);
      run(20, 4'hB);
      check("s3_up_held", 32'(falls[2]), 32'd0);
      run(20, 4'hF);
      run(12, 4'hB);
      run(25, 4'hF);
      check("s3_up_again", 32'(falls[2]), 32'd1);
      check("s3_left_once", 32'(falls[1]), 32'd1);

      // Long hold on left yields one move.
      clr_stats();
      run(100, 4'hD);
      run(25, 4'hF);
      check("s4_count", 32'(falls[1]), 32'd1);
      check("s4_width", 32'(lows[1]), 32'd5);

      // Reset in the third pulse cycle while right stays held.
      clr_stats();
      raw   = 4'hE;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle();
         if (!prev_obs[0]) found = 1'b1;
      end
      check("s5_pulse_seen", 32'(found), 32'h1);
      cycle();
      cycle();
      apply_reset();
      clr_stats();
      run(40, 4'hE);
      check("s5_no_move_held", 32'(falls[0]), 32'd0);
      run(25, 4'hF);
      run(12, 4'hE);
      run(25, 4'hF);
      check("s5_repress", 32'(falls[0]), 32'd1);

      // Random button activity against the model.
      total = 0;
      while (total < 800) begin
         len  = $urandom_range(1, 12);
         kind = $urandom_range(0, 3);
         case (kind)
            0:       v = 4'hF;
            1:       v = ~(4'b0001 << $urandom_range(0, 3));
            2:       v = 4'($urandom_range(0, 15));
            default: v = raw;
         endcase
         run(len, v);
         total += len;
      end
      run(30, 4'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
